// File: rtl/fir_result_sink.sv
// fir_result_sink: consumer end of the FIR output interface.
// Captures done_in-qualified results into a first-word-fall-through FIFO,
// tags frame boundaries, streams them out on valid/ready and drives
// watermark backpressure (stop_out) back to the FIR controller.
// Optional: define FIR_SINK_PEAK_EN to add the peak_abs output.
module fir_result_sink #(
   parameter int unsigned DATAWIDTH = 16,
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned HI_WM     = 6,
   parameter int unsigned LO_WM     = 2,
   parameter int unsigned FRAME_LEN = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic signed [2*DATAWIDTH-1:0]   y_in,
   input  logic                            done_in,
   output logic                            stop_out,
   input  logic                            flush,
   input  logic                            clr_ovf,
   output logic signed [2*DATAWIDTH-1:0]   m_data,
   output logic                            m_last,
   output logic                            m_valid,
   input  logic                            m_ready,
   output logic [$clog2(DEPTH):0]          count,
   output logic                            overflow
`ifdef FIR_SINK_PEAK_EN
   ,
   output logic [2*DATAWIDTH-1:0]          peak_abs
`endif
);

   localparam int unsigned RW = 2 * DATAWIDTH;
   localparam int unsigned EW = RW + 1;
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

   typedef enum logic {
      RUN  = 1'b0,
      HOLD = 1'b1
   } state_e;

   // Storage: {last tag, result}
   logic [EW-1:0] mem_q [DEPTH];

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [FW-1:0] frm_q, frm_d;
   logic          overflow_q, overflow_d;
   state_e        state_q, state_d;

   logic          full;
   logic          pop;
   logic          push_ok;
   logic          drop;
   logic          last_tag;
   logic [EW-1:0] head;

   // Head-of-FIFO presentation, gated so an empty FIFO shows zeros
   always_comb begin
      head     = mem_q[rd_ptr_q];
      m_valid  = (count_q != '0);
      m_data   = m_valid ? $signed(head[RW-1:0]) : '0;
      m_last   = m_valid & head[RW];
      count    = count_q;
      overflow = overflow_q;
      stop_out = (state_q == HOLD);
   end

   // Handshake decode: flush masks both push and pop
   always_comb begin
      full     = (count_q == CW'(DEPTH));
      pop      = m_valid & m_ready & ~flush;
      push_ok  = done_in & ~flush & (~full | pop);
      drop     = done_in & ~flush & full & ~pop;
      last_tag = (frm_q == FW'(FRAME_LEN - 1));
   end

   // Next-state for pointers, occupancy, frame counter and overflow flag
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      frm_d      = frm_q;
      overflow_d = overflow_q;

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         frm_d    = '0;
      end else begin
         if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            frm_d    = last_tag ? '0 : frm_q + FW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         count_d = count_q + CW'(push_ok) - CW'(pop);
      end

      if (drop) begin
         overflow_d = 1'b1;
      end else if (clr_ovf) begin
         overflow_d = 1'b0;
      end
   end

   // Backpressure next state, evaluated on the post-edge occupancy
   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (count_d >= CW'(HI_WM)) state_d = HOLD;
         HOLD:    if (count_d <= CW'(LO_WM)) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   // Control registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         frm_q      <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         frm_q      <= frm_d;
         overflow_q <= overflow_d;
      end
   end

   // Backpressure FSM state register; stop_out decodes HOLD
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Data array write; contents are only observed through count-gated reads
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= {last_tag, y_in};
      end
   end

`ifdef FIR_SINK_PEAK_EN
   logic [RW-1:0] y_abs;
   logic [RW-1:0] peak_q, peak_d;

   // Magnitude of the incoming result; most negative value saturates
   always_comb begin
      if (y_in == $signed({1'b1, {(RW-1){1'b0}}})) begin
         y_abs = {1'b0, {(RW-1){1'b1}}};
      end else if (y_in[RW-1]) begin
         y_abs = $unsigned(-y_in);
      end else begin
         y_abs = $unsigned(y_in);
      end
   end

   // Running peak over accepted pushes, cleared by flush
   always_comb begin
      peak_d = peak_q;
      if (flush) begin
         peak_d = '0;
      end else if (push_ok && (y_abs > peak_q)) begin
         peak_d = y_abs;
      end
   end

   // Peak register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         peak_q <= '0;
      end else begin
         peak_q <= peak_d;
      end
   end

   assign peak_abs = peak_q;
`endif

endmodule

// File: tb/tb_fir_result_sink.sv
// Directed bench for fir_result_sink with default parameters
// (DATAWIDTH=16, DEPTH=8, HI_WM=6, LO_WM=2, FRAME_LEN=4).
module tb_fir_result_sink;

   logic               clk;
   logic               rst;
   logic signed [31:0] y_in;
   logic               done_in;
   logic               stop_out;
   logic               flush;
   logic               clr_ovf;
   logic signed [31:0] m_data;
   logic               m_last;
   logic               m_valid;
   logic               m_ready;
   logic [3:0]         count;
   logic               overflow;
`ifdef FIR_SINK_PEAK_EN
   logic [31:0]        peak_abs;
`endif

   int passed = 0;
   int total  = 0;

   fir_result_sink dut (
      .clk      (clk),
      .rst      (rst),
      .y_in     (y_in),
      .done_in  (done_in),
      .stop_out (stop_out),
      .flush    (flush),
      .clr_ovf  (clr_ovf),
      .m_data   (m_data),
      .m_last   (m_last),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .count    (count),
      .overflow (overflow)
`ifdef FIR_SINK_PEAK_EN
      ,
      .peak_abs (peak_abs)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int v);
      done_in = 1'b1;
      y_in    = v;
      tick();
      done_in = 1'b0;
   endtask

   initial begin
      rst = 1'b1; y_in = '0; done_in = 1'b0; flush = 1'b0; clr_ovf = 1'b0; m_ready = 1'b0;
      #2 rst = 1'b0;
      #2;
      check("rst_count", count, 0);
      check("rst_valid", m_valid, 0);
      check("rst_last", m_last, 0);
      check("rst_data", m_data, 0);
      check("rst_stop", stop_out, 0);
      check("rst_ovf", overflow, 0);
      tick();
      rst = 1'b1;
      tick();

      // Basic streaming with the consumer always ready
      m_ready = 1'b1;
      push(10);
      check("bs_d0", m_data, 10);   check("bs_l0", m_last, 0); check("bs_c0", count, 1);
      push(-20);
      check("bs_d1", m_data, -20);  check("bs_l1", m_last, 0); check("bs_c1", count, 1);
      push(30);
      check("bs_d2", m_data, 30);   check("bs_l2", m_last, 0); check("bs_c2", count, 1);
      push(-40);
      check("bs_d3", m_data, -40);  check("bs_l3", m_last, 1); check("bs_c3", count, 1);
      tick();
      check("bs_empty", m_valid, 0);
`ifdef FIR_SINK_PEAK_EN
      check("pk_basic", peak_abs, 40);
`endif

      // Backpressure: six pushes with consumer stalled
      m_ready = 1'b0;
      for (int i = 1; i <= 5; i++) push(i);
      check("bp_c5", count, 5);
      check("bp_stop5", stop_out, 0);
      push(6);
      check("bp_c6", count, 6);
      check("bp_stop6", stop_out, 1);
      m_ready = 1'b1;
      check("bp_h1", m_data, 1);
      tick(); check("bp_c_5", count, 5); check("bp_s_5", stop_out, 1);
      tick(); check("bp_c_4", count, 4); check("bp_s_4", stop_out, 1);
      tick(); check("bp_c_3", count, 3); check("bp_s_3", stop_out, 1);
      check("bp_h4", m_data, 4);
      tick(); check("bp_c_2", count, 2); check("bp_s_2", stop_out, 0);
      tick(); tick();
      check("bp_drained", count, 0);

      // Flush realigns the frame counter for the overflow test
      flush = 1'b1; tick(); flush = 1'b0;
      check("fl0_count", count, 0);

      // Overflow: nine pushes into an eight-entry FIFO
      m_ready = 1'b0;
      for (int i = 0; i < 8; i++) push(100 + i);
      check("of_c8", count, 8);
      check("of_ovf0", overflow, 0);
      push(108);
      check("of_c8b", count, 8);
      check("of_ovf1", overflow, 1);
      check("of_stop", stop_out, 1);
      m_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("of_d%0d", i), m_data, 100 + i);
         check($sformatf("of_l%0d", i), m_last, (i == 3 || i == 7) ? 1 : 0);
         tick();
      end
      check("of_empty", m_valid, 0);
      check("of_stop_end", stop_out, 0);
      check("of_ovf_kept", overflow, 1);
      clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
      check("of_clr", overflow, 0);

      // Full with simultaneous push and pop
      m_ready = 1'b0;
      for (int i = 0; i < 8; i++) push(200 + i);
      check("fp_c8", count, 8);
      m_ready = 1'b1;
      push(208);
      check("fp_c8b", count, 8);
      check("fp_ovf", overflow, 0);
      check("fp_head", m_data, 201);

      // Clear/set race: drop wins over clr_ovf
      m_ready = 1'b0;
      clr_ovf = 1'b1;
      push(209);
      check("rc_ovf_set", overflow, 1);
      check("rc_c8", count, 8);
      tick();
      clr_ovf = 1'b0;
      check("rc_ovf_clr", overflow, 0);
      m_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("fp_d%0d", i), m_data, 201 + i);
         check($sformatf("fp_l%0d", i), m_last, (i == 2 || i == 6) ? 1 : 0);
         tick();
      end
      check("fp_empty", count, 0);

      // Flush with count=5 and sticky overflow set
      m_ready = 1'b0;
      for (int i = 0; i < 9; i++) push(300 + i);
      check("fl_ovf_pre", overflow, 1);
      m_ready = 1'b1;
      tick(); tick(); tick();
      m_ready = 1'b0;
      check("fl_c5", count, 5);
      check("fl_stop_pre", stop_out, 1);
      flush = 1'b1;
      push(999);
      flush = 1'b0;
      check("fl_count", count, 0);
      check("fl_valid", m_valid, 0);
      check("fl_stop", stop_out, 0);
      check("fl_ovf", overflow, 1);
`ifdef FIR_SINK_PEAK_EN
      check("pk_flush", peak_abs, 0);
      push(-32'sh8000_0000);
      check("pk_sat", peak_abs, 32'h7FFF_FFFF);
      flush = 1'b1; tick(); flush = 1'b0;
`endif

      // Frame counter restarts after flush: fourth entry carries the tag
      for (int i = 0; i < 3; i++) push(400 + i);
      check("fl_head_last", m_last, 0);

      // Asynchronous reset mid-stream
      #3 rst = 1'b0;
      #1;
      check("ar_count", count, 0);
      check("ar_valid", m_valid, 0);
      check("ar_data", m_data, 0);
      check("ar_last", m_last, 0);
      check("ar_stop", stop_out, 0);
      check("ar_ovf", overflow, 0);
      tick();
      rst = 1'b1;
      tick();
      check("ar_still_empty", m_valid, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
